// File: rtl/iterative_shifter.sv
// Multi-cycle shifter for SLL / SRL / SRA / ROL, moving at most STEP positions
// per clock. A start/done handshake lets the control unit stall while it runs.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   start  - request a shift (sampled only in IDLE)
//   op     - 00 SLL, 01 SRL, 11 SRA, 10 ROL
//   a      - operand, sampled on the accepting edge
//   shamt  - shift amount 0..N-1, sampled on the accepting edge
//   busy   - high while in SHIFT or DONE
//   done   - one-cycle pulse when result becomes valid
//   result - shifted value, held until the next accepted start
module iterative_shifter #(
    parameter int unsigned N    = 32,
    parameter int unsigned STEP = 1,
    parameter int unsigned SW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] shamt,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROL = 2'b10,
        OP_SRA = 2'b11
    } mode_e;

    localparam logic [SW-1:0] STEP_AMT = SW'(STEP);
    localparam logic [SW:0]   N_AMT    = (SW+1)'(N);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [N-1:0]  work_q, work_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  result_q, result_d;

    logic [SW-1:0]       step_amt_c;
    logic [SW:0]         rot_amt_c;
    logic signed [N-1:0] work_s_c;
    logic [N-1:0]        shifted_c;

    // One step of the datapath: shift by min(STEP, cnt) according to mode.
    // SRA keeps the operand MSB at every step, so the fill is always the
    // sign bit latched at start.
    always_comb begin
        step_amt_c = (cnt_q > STEP_AMT) ? STEP_AMT : cnt_q;
        rot_amt_c  = N_AMT - {1'b0, step_amt_c};
        work_s_c   = work_q;
        shifted_c  = work_q;
        case (mode_q)
            OP_SLL:  shifted_c = work_q << step_amt_c;
            OP_SRL:  shifted_c = work_q >> step_amt_c;
            OP_SRA:  shifted_c = N'(work_s_c >>> step_amt_c);
            OP_ROL:  shifted_c = (work_q << step_amt_c) | (work_q >> rot_amt_c);
            default: shifted_c = work_q;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = a;
                    cnt_d   = shamt;
                    mode_d  = mode_e'(op);
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = shifted_c;
                    cnt_d  = cnt_q - step_amt_c;
                end else begin
                    result_d = work_q;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= OP_SLL;
            work_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: one STEP=1 and one STEP=4
// instance, compared against an arithmetic reference model.
module tb_iterative_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        s1_start = 1'b0, s4_start = 1'b0;
    logic [1:0]  s1_op = 2'b00, s4_op = 2'b00;
    logic [31:0] s1_a = '0, s4_a = '0;
    logic [4:0]  s1_shamt = '0, s4_shamt = '0;
    logic        s1_busy, s4_busy, s1_done, s4_done;
    logic [31:0] s1_result, s4_result;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    iterative_shifter #(.N(32), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst_n), .start(s1_start), .op(s1_op), .a(s1_a),
        .shamt(s1_shamt), .busy(s1_busy), .done(s1_done), .result(s1_result)
    );

    iterative_shifter #(.N(32), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst_n), .start(s4_start), .op(s4_op), .a(s4_a),
        .shamt(s4_shamt), .busy(s4_busy), .done(s4_done), .result(s4_result)
    );

    // Reference model: plain arithmetic on a 64-bit scratch value.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input int sh);
        logic [63:0] wide;
        case (op)
            2'b00: wide = {32'b0, a} << sh;
            2'b01: wide = {32'b0, a} >> sh;
            2'b11: wide = {{32{a[31]}}, a} >> sh;
            default: wide = ({32'b0, a} << sh) | ({32'b0, a} << (sh + 32));
        endcase
        if (op == 2'b10) return wide[63:32] | wide[31:0] & 32'hFFFF_FFFF ? rol(a, sh) : rol(a, sh);
        return wide[31:0];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] a, input int sh);
        logic [63:0] dbl;
        dbl = {a, a} << sh;
        return dbl[63:32];
    endfunction

    function automatic int model_lat(input int sh, input int step);
        return (sh + step - 1) / step + 1;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? s1_busy : s4_busy;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 1) ? s1_done : s4_done;
    endfunction

    function automatic logic [31:0] get_result(input int sel);
        return (sel == 1) ? s1_result : s4_result;
    endfunction

    task automatic set_in(input int sel, input logic st, input logic [1:0] op,
                          input logic [31:0] a, input logic [4:0] sh);
        if (sel == 1) begin
            s1_start = st; s1_op = op; s1_a = a; s1_shamt = sh;
        end else begin
            s4_start = st; s4_op = op; s4_a = a; s4_shamt = sh;
        end
    endtask

    // Issue one operation and observe it; optionally scramble inputs and
    // toggle start every cycle while it runs.
    task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] sh, input bit noise,
                          output logic [31:0] res, output int lat, output int bcyc,
                          output int pulses, output bit timeout);
        bit finished;
        lat = 0; bcyc = 0; pulses = 0; timeout = 1'b0; finished = 1'b0;
        @(negedge clk);
        set_in(sel, 1'b1, op, a, sh);
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 300; j++) begin
            if (get_busy(sel)) bcyc++;
            if (get_done(sel)) begin
                pulses++;
                if (lat == 0) lat = j;
            end
            if (!get_busy(sel)) begin
                finished = 1'b1;
                break;
            end
            if (noise)
                set_in(sel, (j % 2) == 0, 2'($urandom), $urandom, 5'($urandom));
            else
                set_in(sel, 1'b0, 2'($urandom), $urandom, 5'($urandom));
            @(negedge clk);
        end
        set_in(sel, 1'b0, 2'b00, '0, '0);
        res = get_result(sel);
        if (!finished) begin
            timeout = 1'b1;
            vectors++;
            miscompares++;
            $display("FAIL timeout: busy still %0b after 300 cycles, required 0", get_busy(sel));
        end
    endtask

    task automatic test_reset;
        vectors++;
        if (s1_busy !== 1'b0 || s1_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_s1_flags: busy=%b done=%b required 0 0", s1_busy, s1_done);
        end
        vectors++;
        if (s1_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_s1_result: got %h required 00000000", s1_result);
        end
        vectors++;
        if (s4_busy !== 1'b0 || s4_done !== 1'b0 || s4_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_s4: busy=%b done=%b result=%h required 0 0 0",
                     s4_busy, s4_done, s4_result);
        end
    endtask

    // Check one completed op against expected values.
    task automatic test_one(input string name, input int sel, input logic [1:0] op,
                            input logic [31:0] a, input logic [4:0] sh,
                            input logic [31:0] exp_res, input int exp_lat, input bit noise);
        logic [31:0] res;
        int lat, bcyc, pulses;
        bit to;
        run_op(sel, op, a, sh, noise, res, lat, bcyc, pulses, to);
        vectors++;
        if (res !== exp_res) begin
            miscompares++;
            $display("FAIL %s result: got %h required %h (op=%b a=%h sh=%0d)",
                     name, res, exp_res, op, a, sh);
        end
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        vectors++;
        if (pulses != 1 || bcyc != exp_lat + 1) begin
            miscompares++;
            $display("FAIL %s handshake: pulses %0d busy_cycles %0d required 1 and %0d",
                     name, pulses, bcyc, exp_lat + 1);
        end
    endtask

    task automatic test_directed;
        test_one("sll31",  1, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 1'b0);
        test_one("sra4",   1, 2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 5,  1'b0);
        test_one("srl4",   1, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 5,  1'b0);
        test_one("rol7s4", 4, 2'b10, 32'h8000_0001, 5'd7,  32'h0000_00C0, 3,  1'b0);
        test_one("sh0s1",  1, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  1'b0);
        test_one("sh0s4",  4, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  1'b0);
        test_one("sll31s4", 4, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9, 1'b0);
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a;
        int          sh;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            sh = $urandom_range(0, 31);
            test_one("rand_s1", 1, op, a, 5'(sh), model(op, a, sh), model_lat(sh, 1), 1'b0);
            op = 2'($urandom);
            a  = $urandom;
            sh = $urandom_range(0, 31);
            test_one("rand_s4", 4, op, a, 5'(sh), model(op, a, sh), model_lat(sh, 4), 1'b0);
        end
    endtask

    task automatic test_start_ignored;
        logic [31:0] a;
        a = $urandom | 32'h1;
        test_one("noise_sll10", 1, 2'b00, a, 5'd10, model(2'b00, a, 10), 11, 1'b1);
        a = $urandom;
        test_one("after_noise", 1, 2'b11, a, 5'd3, model(2'b11, a, 3), 4, 1'b0);
        a = $urandom;
        test_one("noise_s4", 4, 2'b10, a, 5'd13, model(2'b10, a, 13), 5, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, exp;
        a = $urandom;
        exp = model(2'b01, a, 9);
        test_one("b2b_first", 4, 2'b01, a, 5'd9, exp, 4, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if (s4_result !== exp || s4_busy !== 1'b0 || s4_done !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: result %h busy %b done %b required %h 0 0",
                     s4_result, s4_busy, s4_done, exp);
        end
        a = $urandom;
        test_one("b2b_second", 4, 2'b00, a, 5'd1, model(2'b00, a, 1), 2, 1'b0);
    endtask

    task automatic test_reset_mid;
        int pulses;
        test_one("pre_reset", 1, 2'b00, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 1, 1'b0);
        @(negedge clk);
        set_in(1, 1'b1, 2'b00, 32'h1234_5678, 5'd10);
        @(posedge clk);
        @(negedge clk);
        set_in(1, 1'b0, 2'b00, '0, '0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (s1_busy !== 1'b0 || s1_done !== 1'b0 || s1_result !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: busy %b done %b result %h required 0 0 00000000",
                     s1_busy, s1_done, s1_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s1_done || s1_busy) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_abandon: saw %0d busy/done cycles required 0", pulses);
        end
        test_one("post_reset", 1, 2'b10, 32'hF000_000F, 5'd4, 32'h0000_00FF, 5, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Multi-cycle, parametrised shifter for the RV32I shift instructions SLL, SRL and SRA, plus a rotate-left mode.
- Shifts an N-bit operand by 0..N-1 positions, moving at most STEP positions per clock.
- A start/done handshake lets the control unit stall the pipeline while the shift runs.
- Replaces fixed shift-by-one wiring wherever a variable shift amount is needed, such as the ALU shift path.

Parameters:
- N, default 32: operand and result width; must be a power of 2, at least 8.
- STEP, default 1: maximum positions shifted per clock; must be a power of 2 with 1 <= STEP <= N/2.
- SW, default $clog2(N): width of the shift-amount port.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-low reset.
- start, input, 1: request a shift; sampled only in IDLE.
- op, input, 2: shift mode; 00 = SLL, 01 = SRL, 11 = SRA, 10 = ROL.
- a, input, N: operand; sampled on the accepting edge.
- shamt, input, SW: shift amount, 0..N-1; sampled on the accepting edge.
- busy, output, 1: high while in SHIFT or DONE; start is ignored while high.
- done, output, 1: one-cycle pulse; result is valid from this cycle onward.
- result, output, N: shifted value; held until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous, any state, including mid-shift): state goes to IDLE; busy=0, done=0, result=0; internal operand, count and mode registers are cleared. Any operation in progress is abandoned with no done pulse. Leaving reset is synchronous to clk.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE, when start=1: latch a into the working register, shamt into cnt, and op into mode. Go to SHIFT; busy=1.
- IDLE, when start=0: stay in IDLE.
- SHIFT, when cnt > 0:
  - k = min(STEP, cnt).
  - Shift the working register by k positions according to mode.
  - cnt = cnt - k.
  - Stay in SHIFT.
- SHIFT, when cnt = 0: copy the working register to result, set done=1, go to DONE.
- Per-mode shift rules:
  - SLL: zero-fill from the LSB side.
  - SRL: zero-fill from the MSB side.
  - SRA: fill with bit N-1 of the operand latched at start.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- DONE: done=0 on the next edge; go to IDLE; busy=0. Exactly one done pulse per accepted start.
- Latency: the number of rising edges from the accepting edge to the edge that raises done is ceil(shamt/STEP) + 1.
  - shamt=0 gives 1 edge; result = a.
  - N=32, STEP=1, shamt=31 gives 32 edges.
  - N=32, STEP=4, shamt=31 gives 9 edges.
- start asserted in SHIFT or DONE: ignored, not queued; a, shamt and op are not sampled.
- The earliest next accept is the edge after DONE, i.e. in IDLE.
- Changes to a, shamt or op after the accepting edge have no effect on the operation in flight.
- The shift amount is unsigned and never exceeds N-1, so no wrap or modulo handling is required.
- The final SHIFT step may be a partial step: k = cnt < STEP.
- op=10 (ROL) is not a RISC-V instruction; it is provided for the future Zbb extension.
- result changes only on the edge entering DONE or on reset.

Test Plan:
- N=32, STEP=1, op=SLL, a=0x00000001, shamt=31 -> done 32 edges after accept; result=0x80000000; busy high for 33 cycles.
- N=32, STEP=1:
  - op=SRA, a=0x80000000, shamt=4 -> result=0xF8000000.
  - Repeat with op=SRL -> result=0x08000000.
  - Both complete in 5 edges.
- N=32, STEP=4, op=ROL, a=0x80000001, shamt=7 -> two SHIFT steps (4, then 3); done after 3 edges; result=0x000000C0.
- shamt=0, op=SLL, a=0xDEADBEEF -> done after 1 edge; result=0xDEADBEEF.
- start toggled every cycle during a shamt=10 SLL, with a and shamt changing each cycle -> exactly one done pulse and result computed from the originally latched inputs. The next start is accepted only after busy falls.
- rst pulsed low while cnt=5 -> busy=0, done=0 and result=0 immediately without waiting for a clock edge; no done pulse follows. A fresh start after reset completes normally.
